// File: rtl/booth_mul_r4.sv
// -----------------------------------------------------------------------------
// booth_mul_r4
// Sequential radix-4 Booth multiplier. One Booth digit is retired per RUN
// cycle; the full 2*WIDTH-bit two's-complement product is registered on the
// last iteration and held until the next accepted start.
//
// Parameters
//   WIDTH         operand width (even, 8..128)
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   start         begin a multiply (sampled only in IDLE)
//   is_signed     operand signedness, latched with start
//                 (present only when BOOTH_MUL_UNSIGNED_EN is defined)
//   multiplier    operand added/subtracted into the upper partial product
//   multiplicand  operand whose bit-pairs are Booth-recoded
//   busy          high while in RUN
//   done          one-cycle pulse marking a valid result
//   result        2*WIDTH-bit product
//
// Configuration macro
//   BOOTH_MUL_UNSIGNED_EN  adds is_signed; with is_signed=0 the operands are
//                          zero-extended and one extra iteration is run.
// -----------------------------------------------------------------------------
module booth_mul_r4 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
`ifdef BOOTH_MUL_UNSIGNED_EN
    input  logic                 is_signed,
`endif
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    // Operands carry 2 extension bits; the upper accumulator 2 more for +/-2M.
    localparam int unsigned EW    = WIDTH + 2;
    localparam int unsigned AW    = WIDTH + 4;
    localparam int unsigned RW    = 2 * WIDTH;
    localparam int unsigned FW    = AW + EW;
    localparam int unsigned N_SGN = WIDTH / 2;
    localparam int unsigned N_UNS = WIDTH / 2 + 1;
    localparam int unsigned CW    = $clog2(WIDTH / 2 + 2);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [EW-1:0]   r_m;
    logic [EW-1:0]   r_q;
    logic            r_q_prev;
    logic [AW-1:0]   r_a;
    logic [CW-1:0]   r_cnt;
    logic            r_signed;

    logic            w_start_signed;
    logic            w_ext_m;
    logic            w_ext_q;
    logic [CW-1:0]   w_last;
    logic [AW-1:0]   w_m_aw;
    logic [AW-1:0]   w_m2_aw;
    logic [AW-1:0]   w_term;
    logic [AW-1:0]   w_sum;
    logic [AW-1:0]   w_a_next;
    logic [EW-1:0]   w_q_next;
    logic [FW-1:0]   w_full;
    logic [RW-1:0]   w_prod;
    logic            w_unused_hi;

`ifdef BOOTH_MUL_UNSIGNED_EN
    assign w_start_signed = is_signed;
`else
    assign w_start_signed = 1'b1;
`endif

    // Extension bits: sign bit in signed mode, zero in unsigned mode.
    assign w_ext_m = w_start_signed & multiplier[WIDTH-1];
    assign w_ext_q = w_start_signed & multiplicand[WIDTH-1];

    // Index of the final iteration for the latched mode.
    assign w_last = r_signed ? CW'(N_SGN - 1) : CW'(N_UNS - 1);

    assign w_m_aw  = {{2{r_m[EW-1]}}, r_m};
    assign w_m2_aw = {w_m_aw[AW-2:0], 1'b0};

    // Booth digit select on {q[1], q[0], q_prev}.
    always_comb begin
        w_term = '0;
        case ({r_q[1:0], r_q_prev})
            3'b001, 3'b010: w_term = w_m_aw;
            3'b011:         w_term = w_m2_aw;
            3'b100:         w_term = ~w_m2_aw + AW'(1);
            3'b101, 3'b110: w_term = ~w_m_aw + AW'(1);
            default:        w_term = '0;
        endcase
    end

    // Add into the upper half, then shift {A, Q} right by 2 arithmetically.
    assign w_sum    = r_a + w_term;
    assign w_a_next = {{2{w_sum[AW-1]}}, w_sum[AW-1:2]};
    assign w_q_next = {w_sum[1:0], r_q[EW-1:2]};

    // Signed mode leaves 2 unconsumed multiplicand bits at the bottom of Q.
    assign w_full      = {w_a_next, w_q_next};
    assign w_prod      = r_signed ? w_full[RW+1:2] : w_full[RW-1:0];
    assign w_unused_hi = ^w_full[FW-1:RW+2];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = S_RUN;
            S_RUN:   if (r_cnt == w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_m      <= '0;
            r_q      <= '0;
            r_q_prev <= 1'b0;
            r_a      <= '0;
            r_cnt    <= '0;
            r_signed <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            busy <= (w_state_next == S_RUN);
            done <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_m      <= {{2{w_ext_m}}, multiplier};
                        r_q      <= {{2{w_ext_q}}, multiplicand};
                        r_q_prev <= 1'b0;
                        r_a      <= '0;
                        r_cnt    <= '0;
                        r_signed <= w_start_signed;
                    end
                end
                S_RUN: begin
                    r_a      <= w_a_next;
                    r_q      <= w_q_next;
                    r_q_prev <= r_q[1];
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == w_last) begin
                        result <= w_prod;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
